wb_stage: RTL
=============

# wb_stage

Parametrised writeback stage for the pipelined RV32 core: the MEM/WB pipeline register plus a result-select mux. It sign/zero-extends sub-word loads from lane-aligned read data, supports stall and flush from the hazard unit, and suppresses writes to x0. It drives the register-file write port and the forwarding network. It can optionally count retired instructions.

## Interface
- DATA_WIDTH, 32: result and datapath width; legal values are 32 or 64.
- REG_ADDR_W, 5: register index width.
- CNT_WIDTH, 64: retired-instruction counter width.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- StallW  in  1  hold the W register.
- FlushW  in  1  load a bubble into the W register; overrides StallW.
- ValidM  in  1  M-stage instruction valid.
- RegWriteM  in  1  M-stage register write enable.
- RdM  in  REG_ADDR_W  destination register.
- ResultSrcM  in  3  result select.
- Funct3M  in  3  load type.
- ALUResultM  in  DATA_WIDTH  ALU result / load address.
- ReadDataM  in  32  data memory word, 4-byte aligned.
- PC_PlusM  in  DATA_WIDTH  PC+4.
- ImmExtM  in  DATA_WIDTH  extended immediate (LUI).
- ResultW  out  DATA_WIDTH  writeback data.
- RdW  out  REG_ADDR_W  writeback register.
- RegWriteW  out  1  register-file write enable.
- ValidW  out  1  W-stage instruction valid.
- InstRetW  out  CNT_WIDTH  retired-instruction count.

## Operation
- On every clk edge the W register updates with the following priority:
  - rst: all fields are set to 0.
  - Else FlushW: all fields are set to 0.
  - Else StallW: all fields hold.
  - Else: all M-stage inputs are captured.
- Registered fields: ValidM, RegWriteM & ValidM & (RdM != 0), RdM, ResultSrcM, Funct3M, ALUResultM, ReadDataM, PC_PlusM, ImmExtM.
- ResultW is combinational from the registered fields:
  - 000: ALUResult.
  - 001: LoadExt.
  - 010: PC_Plus.
  - 011: ImmExt.
  - Any other value: 0.
- LoadExt uses the low two bits of the registered ALUResult (a = ALUResult[1:0]):
  - Byte lane = ReadData[8a+7:8a].
  - Half lane = ReadData[16·a[1]+15:16·a[1]]; a[0] is ignored.
  - Funct3 000 (LB): sign-extend byte lane. 100 (LBU): zero-extend byte lane.
  - Funct3 001 (LH): sign-extend half lane. 101 (LHU): zero-extend half lane.
  - Funct3 010 (LW): sign-extend the 32-bit word to DATA_WIDTH. 110 (LWU): zero-extend the word.
  - Funct3 011/111: zero-extended word.
- RegWriteW is never 1 while RdW == 0 or ValidW == 0.

## Timing
- Latency: M inputs appear on the W outputs 1 cycle after the capturing edge. ResultW has no additional register.
- Reset values: ValidW=0, RegWriteW=0, RdW=0, ResultW=0 (src 000, ALUResult 0), InstRetW=0.
- A stall may last any number of cycles; outputs stay constant throughout.
- FlushW with StallW set: flush wins, and a bubble is loaded.
- Reset asserted mid-stall or mid-flush: reset wins; state is as at power-up on the next cycle.
- Retirement: the instruction in W retires on an edge where ValidW & (FlushW | ~StallW) & ~rst. InstRetW increments by 1 on that edge, becoming visible the next cycle.
- InstRetW wraps from 2^CNT_WIDTH−1 to 0.

## Configuration
- WB_INSTRET_EN defined: the retirement counter is implemented as described.
- WB_INSTRET_EN undefined: no counter flops; the InstRetW port remains and is tied to 0.

## Test plan
- Reset, then release with an idle M stage (ValidM=0) -> all outputs 0 and InstRetW=0 every cycle.
- LB, ReadDataM=0x80FF7F01, ALUResultM=0x1002 -> ResultW=0xFFFFFFFF; same with LBU -> 0x000000FF; LH at 0x1002 -> 0xFFFF80FF; LHU at 0x1001 -> 0x00007F01.
- ResultSrcM=010 with PC_PlusM=0x104, then 011 with ImmExtM=0x12345000 -> ResultW=0x104, then 0x12345000, each one cycle after capture.
- RegWriteM=1, RdM=0, ValidM=1 -> RegWriteW=0, ValidW=1. RdM=5 -> RegWriteW=1, RdW=5.
- Capture ALUResultM=0xA, then StallW for 3 cycles while M inputs change -> ResultW stays 0xA. Then FlushW with StallW=1 -> ValidW=0, RegWriteW=0, and InstRetW +1 (the stalled instruction retired).
- With WB_INSTRET_EN, 10 back-to-back valid instructions -> InstRetW=10. With CNT_WIDTH=4, 17 instructions -> InstRetW=1. Without the macro -> InstRetW stays 0.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the pipelined RV32 core.
// Holds the MEM/WB pipeline register and the result-select mux, and extends
// sub-word loads from a lane-aligned 32-bit memory word.
// Writes to x0 and writes from invalid slots are dropped when the register
// is loaded, so RegWriteW can never be set for x0 or for a bubble.
// Optional feature macro: WB_INSTRET_EN. When it is defined, a retired
// instruction counter drives InstRetW. When it is undefined, no counter
// flops are built and InstRetW is tied to zero.
module wb_stage #(
  parameter int DATA_WIDTH = 32,  // 32 or 64
  parameter int REG_ADDR_W = 5,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallW,
  input  logic                  FlushW,
  input  logic                  ValidM,
  input  logic                  RegWriteM,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [2:0]            ResultSrcM,
  input  logic [2:0]            Funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [31:0]           ReadDataM,
  input  logic [DATA_WIDTH-1:0] PC_PlusM,
  input  logic [DATA_WIDTH-1:0] ImmExtM,
  output logic [DATA_WIDTH-1:0] ResultW,
  output logic [REG_ADDR_W-1:0] RdW,
  output logic                  RegWriteW,
  output logic                  ValidW,
  output logic [CNT_WIDTH-1:0]  InstRetW
);

  // Result select encodings
  localparam logic [2:0] SRC_ALU  = 3'b000;
  localparam logic [2:0] SRC_LOAD = 3'b001;
  localparam logic [2:0] SRC_PC   = 3'b010;
  localparam logic [2:0] SRC_IMM  = 3'b011;

  // Load type encodings (funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // ---------------------------------------------------------------------------
  // W pipeline register fields
  // ---------------------------------------------------------------------------
  logic                  valid_reg;
  logic                  regwrite_reg;
  logic [REG_ADDR_W-1:0] rd_reg;
  logic [2:0]            src_reg;
  logic [2:0]            funct3_reg;
  logic [DATA_WIDTH-1:0] alu_reg;
  logic [31:0]           rdata_reg;
  logic [DATA_WIDTH-1:0] pc_reg;
  logic [DATA_WIDTH-1:0] imm_reg;

  // Qualified write enable: only a valid instruction that targets a register
  // other than x0 can write.
  logic regwrite_next;

  // Qualify the incoming write enable before it is registered
  always_comb begin
    regwrite_next = RegWriteM & ValidM & (RdM != '0);
  end

  // W register update: reset, then flush (bubble), then stall (hold), then capture
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      rd_reg       <= '0;
      src_reg      <= '0;
      funct3_reg   <= '0;
      alu_reg      <= '0;
      rdata_reg    <= '0;
      pc_reg       <= '0;
      imm_reg      <= '0;
    end else if (FlushW) begin
      valid_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      rd_reg       <= '0;
      src_reg      <= '0;
      funct3_reg   <= '0;
      alu_reg      <= '0;
      rdata_reg    <= '0;
      pc_reg       <= '0;
      imm_reg      <= '0;
    end else if (!StallW) begin
      valid_reg    <= ValidM;
      regwrite_reg <= regwrite_next;
      rd_reg       <= RdM;
      src_reg      <= ResultSrcM;
      funct3_reg   <= Funct3M;
      alu_reg      <= ALUResultM;
      rdata_reg    <= ReadDataM;
      pc_reg       <= PC_PlusM;
      imm_reg      <= ImmExtM;
    end
  end

  // ---------------------------------------------------------------------------
  // Load lane extraction
  // ---------------------------------------------------------------------------
  logic [7:0]  byte_lanes [4];
  logic [1:0]  lane_addr;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Split the registered memory word into its four byte lanes
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign byte_lanes[gi] = rdata_reg[8*gi +: 8];
    end
  endgenerate

  // Pick the byte and half lanes addressed by the low address bits;
  // a misaligned half address simply ignores bit 0.
  always_comb begin
    lane_addr = alu_reg[1:0];
    byte_sel  = byte_lanes[lane_addr];
    half_sel  = lane_addr[1] ? rdata_reg[31:16] : rdata_reg[15:0];
  end

  logic [DATA_WIDTH-1:0] load_ext;

  // Sign/zero extend the selected lane according to the load type
  always_comb begin
    load_ext = '0;
    case (funct3_reg)
      F3_LB:   load_ext = DATA_WIDTH'($signed(byte_sel));
      F3_LBU:  load_ext = DATA_WIDTH'(byte_sel);
      F3_LH:   load_ext = DATA_WIDTH'($signed(half_sel));
      F3_LHU:  load_ext = DATA_WIDTH'(half_sel);
      F3_LW:   load_ext = DATA_WIDTH'($signed(rdata_reg));
      F3_LWU:  load_ext = DATA_WIDTH'(rdata_reg);
      default: load_ext = DATA_WIDTH'(rdata_reg);  // 011 / 111
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result select and outputs
  // ---------------------------------------------------------------------------
  // Choose the writeback value; unused encodings produce zero
  always_comb begin
    ResultW = '0;
    case (src_reg)
      SRC_ALU:  ResultW = alu_reg;
      SRC_LOAD: ResultW = load_ext;
      SRC_PC:   ResultW = pc_reg;
      SRC_IMM:  ResultW = imm_reg;
      default:  ResultW = '0;
    endcase
  end

  assign RdW       = rd_reg;
  assign RegWriteW = regwrite_reg;
  assign ValidW    = valid_reg;

  // ---------------------------------------------------------------------------
  // Retired instruction counter
  // ---------------------------------------------------------------------------
`ifdef WB_INSTRET_EN
  logic                 retire;
  logic [CNT_WIDTH-1:0] instret_reg;

  // The W instruction leaves the stage (and retires) whenever the register is
  // not holding it: either it is overwritten by capture or by a flush.
  always_comb begin
    retire = valid_reg & (FlushW | ~StallW) & ~rst;
  end

  // Count retirements; the counter wraps naturally at its width
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_reg <= '0;
    end else if (retire) begin
      instret_reg <= instret_reg + CNT_WIDTH'(1);
    end
  end

  assign InstRetW = instret_reg;
`else
  assign InstRetW = '0;
`endif

endmodule
